// File: rtl/intra_pred_gen_if.sv
// Request/stream bundle for the intra predictor: block request with neighbour
// pixels on one side, predicted rows with a valid/ready handshake on the other.
interface intra_pred_gen_if;
    logic            start;
    logic [2:0]      mode;
    logic [7:0][7:0] top;
    logic [7:0][7:0] left;
    logic            top_avail;
    logic            left_avail;
    logic            busy;
    logic [63:0]     row_data;
    logic [2:0]      row_idx;
    logic            row_valid;
    logic            row_ready;
    logic            row_last;
    logic            err;

    modport master (
        output start, mode, top, left, top_avail, left_avail, row_ready,
        input  busy, row_data, row_idx, row_valid, row_last, err
    );

    modport slave (
        input  start, mode, top, left, top_avail, left_avail, row_ready,
        output busy, row_data, row_idx, row_valid, row_last, err
    );
endinterface

// File: rtl/intra_pred_gen.sv
// 8x8 intra prediction generator: vertical, horizontal or DC prediction from
// captured neighbours, streamed out one row per handshake.
module intra_pred_gen #(
    parameter int MB_SIZE_L = 8,
    parameter int MB_SIZE_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    intra_pred_gen_if.slave  bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACC    = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;

    localparam logic [1:0] MODE_V  = 2'd0;
    localparam logic [1:0] MODE_H  = 2'd1;
    localparam logic [1:0] MODE_DC = 2'd2;

    localparam logic [2:0] LAST_ROW = 3'(MB_SIZE_L - 1);

    logic [1:0]      r_state;
    logic [1:0]      r_mode;
    logic [7:0][7:0] r_top;
    logic [7:0][7:0] r_left;
    logic            r_tavail;
    logic            r_lavail;
    logic [11:0]     r_sum_t;
    logic [11:0]     r_sum_l;
    logic [2:0]      r_cnt;
    logic [7:0]      r_dc;
    logic            r_busy;
    logic [63:0]     r_row_data;
    logic [2:0]      r_row_idx;
    logic            r_row_valid;
    logic            r_row_last;
    logic            r_err;

    logic            w_fallback;
    logic [1:0]      w_mode_eff;
    logic [11:0]     w_sum_t_nxt;
    logic [11:0]     w_sum_l_nxt;
    logic [7:0]      w_dc;
    logic [2:0]      w_idx_nxt;
    logic            w_hs;
    logic [63:0]     w_row_first;
    logic [63:0]     w_row_dc;
    logic [63:0]     w_row_next;

    function automatic logic [63:0] pred_row(
        input logic [1:0]      m,
        input logic [7:0][7:0] t,
        input logic [7:0][7:0] l,
        input logic [7:0]      dc,
        input logic [2:0]      r
    );
        logic [63:0] row;
        row = 64'd0;
        for (int c = 0; c < MB_SIZE_W; c++) begin
            case (m)
                MODE_V:  row[8*c +: 8] = t[c];
                MODE_H:  row[8*c +: 8] = l[r];
                default: row[8*c +: 8] = dc;
            endcase
        end
        return row;
    endfunction

    // Mode fallback decision and running-sum/row-address datapath
    always_comb begin
        w_fallback  = (bus.mode > 3'd2) ||
                      ((bus.mode == 3'd0) && !bus.top_avail) ||
                      ((bus.mode == 3'd1) && !bus.left_avail);
        w_mode_eff  = w_fallback ? MODE_DC : bus.mode[1:0];
        w_sum_t_nxt = r_sum_t + {4'd0, r_top[r_cnt]};
        w_sum_l_nxt = r_sum_l + {4'd0, r_left[r_cnt]};
        w_idx_nxt   = r_row_idx + 3'd1;
        w_hs        = r_row_valid && bus.row_ready;
    end

    // DC value from the final sums; both sums fit 12 bits so no carry is lost
    always_comb begin
        w_dc = 8'd128;
        case ({r_tavail, r_lavail})
            2'b11:   w_dc = 8'((w_sum_t_nxt + w_sum_l_nxt + 12'd8) >> 4);
            2'b10:   w_dc = 8'((w_sum_t_nxt + 12'd4) >> 3);
            2'b01:   w_dc = 8'((w_sum_l_nxt + 12'd4) >> 3);
            default: w_dc = 8'd128;
        endcase
    end

    // Candidate rows: first row straight from the inputs, DC row 0, next row
    always_comb begin
        w_row_first = pred_row(w_mode_eff, bus.top, bus.left, 8'd0, 3'd0);
        w_row_dc    = pred_row(MODE_DC, r_top, r_left, w_dc, 3'd0);
        w_row_next  = pred_row(r_mode, r_top, r_left, r_dc, w_idx_nxt);
    end

    // Control FSM with registered stream outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_mode      <= MODE_V;
            r_top       <= 64'd0;
            r_left      <= 64'd0;
            r_tavail    <= 1'b0;
            r_lavail    <= 1'b0;
            r_sum_t     <= 12'd0;
            r_sum_l     <= 12'd0;
            r_cnt       <= 3'd0;
            r_dc        <= 8'd0;
            r_busy      <= 1'b0;
            r_row_data  <= 64'd0;
            r_row_idx   <= 3'd0;
            r_row_valid <= 1'b0;
            r_row_last  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_mode   <= w_mode_eff;
                        r_top    <= bus.top;
                        r_left   <= bus.left;
                        r_tavail <= bus.top_avail;
                        r_lavail <= bus.left_avail;
                        r_err    <= w_fallback;
                        r_busy   <= 1'b1;
                        r_sum_t  <= 12'd0;
                        r_sum_l  <= 12'd0;
                        r_cnt    <= 3'd0;
                        if (w_mode_eff == MODE_DC) begin
                            r_state <= ST_ACC;
                        end else begin
                            r_state     <= ST_STREAM;
                            r_row_valid <= 1'b1;
                            r_row_idx   <= 3'd0;
                            r_row_last  <= 1'b0;
                            r_row_data  <= w_row_first;
                        end
                    end
                end
                ST_ACC: begin
                    r_sum_t <= w_sum_t_nxt;
                    r_sum_l <= w_sum_l_nxt;
                    r_cnt   <= r_cnt + 3'd1;
                    if (r_cnt == LAST_ROW) begin
                        r_dc        <= w_dc;
                        r_state     <= ST_STREAM;
                        r_row_valid <= 1'b1;
                        r_row_idx   <= 3'd0;
                        r_row_last  <= 1'b0;
                        r_row_data  <= w_row_dc;
                    end
                end
                ST_STREAM: begin
                    if (w_hs) begin
                        if (r_row_idx == LAST_ROW) begin
                            r_state     <= ST_IDLE;
                            r_row_valid <= 1'b0;
                            r_row_last  <= 1'b0;
                            r_busy      <= 1'b0;
                        end else begin
                            r_row_idx  <= w_idx_nxt;
                            r_row_data <= w_row_next;
                            r_row_last <= (w_idx_nxt == LAST_ROW);
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_row_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.row_data  = r_row_data;
    assign bus.row_idx   = r_row_idx;
    assign bus.row_valid = r_row_valid;
    assign bus.row_last  = r_row_last;
    assign bus.err       = r_err;

endmodule

// File: tb/tb_intra_pred_gen.sv
// Self-checking bench for intra_pred_gen: directed scenarios plus randomized
// blocks compared against an arithmetic reference of the prediction rules.
module tb_intra_pred_gen;

    logic clk = 1'b0;
    logic reset_n;
    int   checks   = 0;
    int   failures = 0;

    intra_pred_gen_if bus_if();

    intra_pred_gen #(.MB_SIZE_L(8), .MB_SIZE_W(8)) dut (
        .clk   (clk),
        .reset (reset_n),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    function automatic bit model_fallback(input logic [2:0] m, input logic ta, input logic la);
        return (m > 3'd2) || (m == 3'd0 && !ta) || (m == 3'd1 && !la);
    endfunction

    function automatic logic [7:0] model_pixel(input logic [2:0] m, input logic [7:0][7:0] t,
                                               input logic [7:0][7:0] l, input logic ta,
                                               input logic la, input int r, input int c);
        int em;
        int st;
        int sl;
        em = model_fallback(m, ta, la) ? 2 : int'(m);
        if (em == 0) return t[c];
        if (em == 1) return l[r];
        st = 0;
        sl = 0;
        for (int k = 0; k < 8; k++) begin
            st += int'(t[k]);
            sl += int'(l[k]);
        end
        if (ta && la) return 8'((st + sl + 8) / 16);
        if (ta)       return 8'((st + 4) / 8);
        if (la)       return 8'((sl + 4) / 8);
        return 8'd128;
    endfunction

    task automatic run_block(input logic [2:0] m, input logic [7:0][7:0] t, input logic [7:0][7:0] l,
                             input logic ta, input logic la, input int stall_pct,
                             input int stall_row, input int stall_len);
        bit          fb;
        int          lat;
        int          exp_lat;
        int          r;
        int          stalls;
        int          cyc;
        int          hold;
        logic        rdy;
        logic [63:0] exp_row;
        fb      = model_fallback(m, ta, la);
        exp_lat = (fb || m == 3'd2) ? 9 : 1;
        bus_if.start      = 1'b1;
        bus_if.mode       = m;
        bus_if.top        = t;
        bus_if.left       = l;
        bus_if.top_avail  = ta;
        bus_if.left_avail = la;
        bus_if.row_ready  = 1'b0;
        @(negedge clk);
        // scramble inputs: the block must use only what was captured
        bus_if.start      = 1'b0;
        bus_if.mode       = 3'($urandom_range(0, 7));
        bus_if.top        = {$urandom(), $urandom()};
        bus_if.left       = {$urandom(), $urandom()};
        bus_if.top_avail  = 1'($urandom_range(0, 1));
        bus_if.left_avail = 1'($urandom_range(0, 1));
        lat = 1;
        while (!bus_if.row_valid && lat < 20) begin
            checks++;
            if (bus_if.busy !== 1'b1) begin
                failures++;
                $display("FAIL busy_before_rows: got %b expected 1", bus_if.busy);
            end
            bus_if.start     = 1'($urandom_range(0, 1));
            bus_if.row_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != exp_lat) begin
            failures++;
            $display("FAIL first_row_latency: got %0d expected %0d", lat, exp_lat);
        end
        r = 0; stalls = 0; cyc = 0; hold = 0;
        while (r < 8 && cyc < 64) begin
            for (int c = 0; c < 8; c++) exp_row[8*c +: 8] = model_pixel(m, t, l, ta, la, r, c);
            checks += 6;
            if (bus_if.row_valid !== 1'b1) begin
                failures++;
                $display("FAIL row_valid: row %0d got %b expected 1", r, bus_if.row_valid);
            end
            if (bus_if.row_idx !== 3'(r)) begin
                failures++;
                $display("FAIL row_idx: got %0d expected %0d", bus_if.row_idx, r);
            end
            if (bus_if.row_data !== exp_row) begin
                failures++;
                $display("FAIL row_data: row %0d got %h expected %h", r, bus_if.row_data, exp_row);
            end
            if (bus_if.row_last !== (r == 7)) begin
                failures++;
                $display("FAIL row_last: row %0d got %b expected %b", r, bus_if.row_last, (r == 7));
            end
            if (bus_if.err !== fb) begin
                failures++;
                $display("FAIL err: got %b expected %b", bus_if.err, fb);
            end
            if (bus_if.busy !== 1'b1) begin
                failures++;
                $display("FAIL busy_stream: got %b expected 1", bus_if.busy);
            end
            if (r == stall_row && hold < stall_len) begin
                rdy = 1'b0;
                hold++;
            end else begin
                rdy = ($urandom_range(0, 99) >= stall_pct);
            end
            if (!rdy) stalls++;
            bus_if.row_ready = rdy;
            bus_if.start     = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
            if (rdy) r++;
        end
        checks += 4;
        if (cyc != 8 + stalls) begin
            failures++;
            $display("FAIL stream_cycles: got %0d expected %0d", cyc, 8 + stalls);
        end
        if (bus_if.row_valid !== 1'b0) begin
            failures++;
            $display("FAIL valid_after_block: got %b expected 0", bus_if.row_valid);
        end
        if (bus_if.busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_after_block: got %b expected 0", bus_if.busy);
        end
        if (bus_if.err !== fb) begin
            failures++;
            $display("FAIL err_held: got %b expected %b", bus_if.err, fb);
        end
        bus_if.start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n           = 1'b0;
        bus_if.start      = 1'b0;
        bus_if.mode       = 3'd0;
        bus_if.top        = 64'd0;
        bus_if.left       = 64'd0;
        bus_if.top_avail  = 1'b0;
        bus_if.left_avail = 1'b0;
        bus_if.row_ready  = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus_if.busy, bus_if.row_valid, bus_if.row_last, bus_if.err} !== 4'd0 ||
            bus_if.row_idx !== 3'd0 || bus_if.row_data !== 64'd0) begin
            failures++;
            $display("FAIL reset_state: got busy=%b valid=%b last=%b err=%b idx=%0d data=%h expected all 0",
                     bus_if.busy, bus_if.row_valid, bus_if.row_last, bus_if.err,
                     bus_if.row_idx, bus_if.row_data);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_vertical();
        logic [7:0][7:0] t;
        for (int c = 0; c < 8; c++) t[c] = 8'(10 * (c + 1));
        run_block(3'd0, t, {$urandom(), $urandom()}, 1'b1, 1'b1, 0, -1, 0);
    endtask

    task automatic test_dc_both();
        logic [7:0][7:0] t;
        logic [7:0][7:0] l;
        for (int c = 0; c < 8; c++) begin
            t[c] = 8'd100;
            l[c] = 8'd50;
        end
        run_block(3'd2, t, l, 1'b1, 1'b1, 0, -1, 0);
    endtask

    task automatic test_dc_none_fallback();
        run_block(3'd0, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b0, 1'b0, 0, -1, 0);
        run_block(3'd1, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b1, 1'b0, 0, -1, 0);
    endtask

    task automatic test_backpressure();
        logic [7:0][7:0] l;
        for (int r = 0; r < 8; r++) l[r] = 8'(r * 3);
        run_block(3'd1, {$urandom(), $urandom()}, l, 1'b1, 1'b1, 0, 2, 5);
    endtask

    task automatic test_rounding();
        logic [7:0][7:0] t;
        for (int c = 0; c < 8; c++) t[c] = (c == 7) ? 8'd0 : 8'd1;
        run_block(3'd2, t, {$urandom(), $urandom()}, 1'b1, 1'b0, 0, -1, 0);
        run_block(3'd5, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b1, 1'b1, 0, -1, 0);
        run_block(3'd2, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b0, 1'b1, 20, -1, 0);
    endtask

    task automatic test_reset_midstream();
        int n;
        bus_if.start      = 1'b1;
        bus_if.mode       = 3'd7;
        bus_if.top        = {$urandom(), $urandom()};
        bus_if.left       = 64'h0102_0304_0506_0708;
        bus_if.top_avail  = 1'b0;
        bus_if.left_avail = 1'b1;
        @(negedge clk);
        bus_if.start     = 1'b0;
        bus_if.row_ready = 1'b1;
        n = 0;
        while (!(bus_if.row_valid && bus_if.row_idx == 3'd4) && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 30) begin
            failures++;
            $display("FAIL reach_row4: got timeout after %0d cycles expected row 4", n);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({bus_if.busy, bus_if.row_valid, bus_if.row_last, bus_if.err} !== 4'd0 ||
            bus_if.row_idx !== 3'd0 || bus_if.row_data !== 64'd0) begin
            failures++;
            $display("FAIL async_reset: got busy=%b valid=%b last=%b err=%b idx=%0d data=%h expected all 0",
                     bus_if.busy, bus_if.row_valid, bus_if.row_last, bus_if.err,
                     bus_if.row_idx, bus_if.row_data);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (bus_if.row_valid !== 1'b0 || bus_if.busy !== 1'b0) begin
                failures++;
                $display("FAIL no_rows_after_reset: got valid=%b busy=%b expected 0 0",
                         bus_if.row_valid, bus_if.busy);
            end
        end
        run_block(3'd0, {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b1, 1'b0, 10, -1, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++)
            run_block(3'(i % 3), {$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'b1, 1'b1, 0, -1, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++)
            run_block(3'($urandom_range(0, 7)), {$urandom(), $urandom()}, {$urandom(), $urandom()},
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 30, -1, 0);
    endtask

    initial begin
        test_reset();
        test_vertical();
        test_dc_both();
        test_dc_none_fallback();
        test_backpressure();
        test_rounding();
        test_reset_midstream();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
